rgb_pwm_fader: RTL and testbench

- Consumer end of the main PWM counter. It receives the 0..9 main count and the direction bit from the main/direction counter block.
- It generates the three registered PWM LED outputs (R, G, B) by comparing the count with per-colour duty levels.
- It runs a colour cross-fade sequencer that steps the duty levels once per group of PWM periods. The sequence order depends on the direction bit.
- Sits between the main/direction counter and the board LED pins.

---
 rtl/rb_led_pkg.sv | 27 ++
 rtl/rgb_pwm_fader_pwm_cmp.sv | 27 ++
 rtl/rgb_pwm_fader.sv | 111 +++++++++++
 tb/tb_rgb_pwm_fader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rb_led_pkg.sv
// Shared constants, sequencer state encoding and colour-order helper for the RGB PWM fader.
package rb_led_pkg;

    localparam int DUTY_W = 4;
    localparam logic [DUTY_W-1:0] MAX_DUTY = 4'd10;
    localparam logic [DUTY_W-1:0] LAST_CNT = 4'd9;

    typedef enum logic [1:0] {
        S_R = 2'd0,
        S_G = 2'd1,
        S_B = 2'd2
    } state_t;

    // Colour that fades in after the current one; dir=0 is R->G->B, dir=1 is R->B->G.
    function automatic state_t next_colour(input state_t state, input logic dir);
        state_t n;
        n = S_R;
        case (state)
            S_R:     n = dir ? S_B : S_G;
            S_G:     n = dir ? S_R : S_B;
            S_B:     n = dir ? S_G : S_R;
            default: n = S_R;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rgb_pwm_fader_pwm_cmp.sv
// Single-channel registered PWM comparator; counts above the last valid count force the output low.
module pwm_cmp
    import rb_led_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DUTY_W-1:0] cnt_i,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_o
);

    logic pwm_d;
    logic pwm_q;

    assign pwm_d = (cnt_i < duty_i) && (cnt_i <= LAST_CNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB PWM LED driver with a period-counted colour cross-fade sequencer.
// Handshake: none; CE_IN is a one-cycle qualifier and MAIN_CNT is sampled on every CLK edge.
module rgb_pwm_fader
    import rb_led_pkg::*;
#(
    parameter int STEP_PERIODS = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              CE_IN,
    input  logic              DIR_CNT,
    input  logic [DUTY_W-1:0] MAIN_CNT,
    output logic              LED_R,
    output logic              LED_G,
    output logic              LED_B,
    output logic [DUTY_W-1:0] DUTY_R,
    output logic [DUTY_W-1:0] DUTY_G,
    output logic [DUTY_W-1:0] DUTY_B,
    output logic              PERIOD_END,
    output logic [1:0]        DBG_STATE
);

    localparam logic [DUTY_W-1:0] STEP_LAST = DUTY_W'(STEP_PERIODS - 1);

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] ramp_q, ramp_d;
    logic [DUTY_W-1:0] pcnt_q, pcnt_d;
    logic              fdir_q, fdir_d;
    logic              pend_q;
    logic [DUTY_W-1:0] duty_q [0:2];
    logic [DUTY_W-1:0] duty_d [0:2];
    logic              period_end_c;
    logic              step_c;
    state_t            nxt_c;

    assign period_end_c = CE_IN && (MAIN_CNT == LAST_CNT);

    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        pcnt_d  = pcnt_q;
        fdir_d  = fdir_q;
        step_c  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            duty_d[i] = duty_q[i];
        end
        nxt_c = next_colour(state_q, DIR_CNT);

        if (period_end_c) begin
            if (pcnt_q == STEP_LAST) begin
                pcnt_d = '0;
                step_c = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 4'd1;
            end
        end

        if (step_c) begin
            fdir_d = DIR_CNT;
            for (int i = 0; i < 3; i++) begin
                duty_d[i] = '0;
            end
            // A direction change mid-fade abandons the old target and restarts from full current colour.
            if ((ramp_q != '0) && (DIR_CNT != fdir_q)) begin
                ramp_d          = '0;
                duty_d[state_q] = MAX_DUTY;
            end else if (ramp_q == LAST_CNT) begin
                state_d       = nxt_c;
                ramp_d        = '0;
                duty_d[nxt_c] = MAX_DUTY;
            end else begin
                ramp_d          = ramp_q + 4'd1;
                duty_d[nxt_c]   = ramp_q + 4'd1;
                duty_d[state_q] = MAX_DUTY - (ramp_q + 4'd1);
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q   <= S_R;
            ramp_q    <= '0;
            pcnt_q    <= '0;
            fdir_q    <= 1'b0;
            pend_q    <= 1'b0;
            duty_q[0] <= MAX_DUTY;
            duty_q[1] <= '0;
            duty_q[2] <= '0;
        end else begin
            state_q   <= state_d;
            ramp_q    <= ramp_d;
            pcnt_q    <= pcnt_d;
            fdir_q    <= fdir_d;
            pend_q    <= period_end_c;
            duty_q[0] <= duty_d[0];
            duty_q[1] <= duty_d[1];
            duty_q[2] <= duty_d[2];
        end
    end

    pwm_cmp u_cmp_r (.clk_i(CLK), .rst_i(CLR), .cnt_i(MAIN_CNT), .duty_i(duty_q[0]), .pwm_o(LED_R));
    pwm_cmp u_cmp_g (.clk_i(CLK), .rst_i(CLR), .cnt_i(MAIN_CNT), .duty_i(duty_q[1]), .pwm_o(LED_G));
    pwm_cmp u_cmp_b (.clk_i(CLK), .rst_i(CLR), .cnt_i(MAIN_CNT), .duty_i(duty_q[2]), .pwm_o(LED_B));

    assign DUTY_R     = duty_q[0];
    assign DUTY_G     = duty_q[1];
    assign DUTY_B     = duty_q[2];
    assign PERIOD_END = pend_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: colour-level model checked every cycle plus pinned literal expectations.
module tb_rgb_pwm_fader;

    localparam int STEP = 4;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       CE_IN = 1'b0;
    logic       DIR_CNT = 1'b0;
    logic [3:0] MAIN_CNT = 4'd0;
    logic       LED_R, LED_G, LED_B, PERIOD_END;
    logic [3:0] DUTY_R, DUTY_G, DUTY_B;
    logic [1:0] DBG_STATE;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    rgb_pwm_fader #(.STEP_PERIODS(STEP)) dut (
        .CLK(CLK), .CLR(CLR), .CE_IN(CE_IN), .DIR_CNT(DIR_CNT), .MAIN_CNT(MAIN_CNT),
        .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
        .DUTY_R(DUTY_R), .DUTY_G(DUTY_G), .DUTY_B(DUTY_B),
        .PERIOD_END(PERIOD_END), .DBG_STATE(DBG_STATE)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: colour indices 0=R 1=G 2=B, level = how far the fade has progressed
    int m_duty [3];
    int m_cur, m_fade_lvl, m_periods;
    bit m_fdir;
    bit m_led [3];
    bit m_pe;

    task automatic model_reset();
        m_duty[0] = 10; m_duty[1] = 0; m_duty[2] = 0;
        m_cur = 0; m_fade_lvl = 0; m_periods = 0; m_fdir = 0;
        for (int c = 0; c < 3; c++) m_led[c] = 0;
        m_pe = 0;
    endtask

    task automatic model_step(input bit dir);
        int tgt;
        tgt = dir ? (m_cur + 2) % 3 : (m_cur + 1) % 3;
        for (int c = 0; c < 3; c++) m_duty[c] = 0;
        if (m_fade_lvl > 0 && dir != m_fdir) begin
            m_fade_lvl = 0;
            m_duty[m_cur] = 10;
        end else begin
            m_fade_lvl++;
            if (m_fade_lvl == 10) begin
                m_cur = tgt;
                m_fade_lvl = 0;
                m_duty[m_cur] = 10;
            end else begin
                m_duty[tgt] = m_fade_lvl;
                m_duty[m_cur] = 10 - m_fade_lvl;
            end
        end
        m_fdir = dir;
    endtask

    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            model_reset();
        end else begin
            int cnt;
            cnt = int'(MAIN_CNT);
            m_pe = CE_IN && cnt == 9;
            for (int c = 0; c < 3; c++) m_led[c] = (cnt < m_duty[c]) && (cnt <= 9);
            if (CE_IN && cnt == 9) begin
                if (m_periods == STEP - 1) begin
                    m_periods = 0;
                    model_step(DIR_CNT);
                end else begin
                    m_periods++;
                end
            end
        end
    end

    // Scoreboard compare on the falling edge
    always @(negedge CLK) begin
        if (chk_en) begin
            check("led_r", int'(LED_R), int'(m_led[0]));
            check("led_g", int'(LED_G), int'(m_led[1]));
            check("led_b", int'(LED_B), int'(m_led[2]));
            check("duty_r", int'(DUTY_R), m_duty[0]);
            check("duty_g", int'(DUTY_G), m_duty[1]);
            check("duty_b", int'(DUTY_B), m_duty[2]);
            check("period_end", int'(PERIOD_END), int'(m_pe));
            check("state", int'(DBG_STATE), m_cur);
            check("duty_sum", int'(DUTY_R) + int'(DUTY_G) + int'(DUTY_B), 10);
        end
    end

    // Driver tasks
    task automatic drive(input bit ce, input int cnt);
        CE_IN = ce;
        MAIN_CNT = 4'(cnt);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_periods(input int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < 10; c++) begin
                if (c == 4 || c == 7) drive(0, c);
                drive(1, c);
            end
        end
        CE_IN = 0;
    endtask

    task automatic do_reset();
        CLR = 1;
        @(posedge CLK);
        #1;
        CLR = 0;
    endtask

    task automatic check_duties(input string name, input int r, input int g, input int b);
        check({name, "_r"}, int'(DUTY_R), r);
        check({name, "_g"}, int'(DUTY_G), g);
        check({name, "_b"}, int'(DUTY_B), b);
    endtask

    initial begin
        #2;
        CLR = 1;
        chk_en = 1;
        repeat (2) @(posedge CLK);
        #1;
        CLR = 0;
        check_duties("reset", 10, 0, 0);
        check("reset_led_r", int'(LED_R), 0);

        // Full red: LED_R high across the sweep, period_end pulse after count 9
        run_periods(1);
        check("red_led_after_9", int'(LED_R), 1);
        check("pe_after_9", int'(PERIOD_END), 1);

        // Async reset mid-PWM drops LEDs without a clock edge
        drive(1, 3);
        check("led_r_before_clr", int'(LED_R), 1);
        #3;
        CLR = 1;
        #1;
        check("async_clr_led_r", int'(LED_R), 0);
        @(posedge CLK);
        #1;
        CLR = 0;

        // Forward fade
        DIR_CNT = 0;
        run_periods(4);
        check_duties("fwd_step1", 9, 1, 0);
        run_periods(8);
        check_duties("fwd_step3", 7, 3, 0);
        // LED_G high only for counts 0..2
        drive(1, 0); check("g3_cnt0", int'(LED_G), 1);
        drive(1, 2); check("g3_cnt2", int'(LED_G), 1);
        drive(1, 3); check("g3_cnt3", int'(LED_G), 0);
        drive(1, 9); check("g3_cnt9", int'(LED_G), 0);
        run_periods(27);
        check_duties("fwd_end", 0, 10, 0);
        check("fwd_state", int'(DBG_STATE), 1);

        // Reverse from reset
        do_reset();
        DIR_CNT = 1;
        run_periods(8);
        check_duties("rev_step2", 8, 0, 2);
        run_periods(32);
        check_duties("rev_end", 0, 0, 10);
        check("rev_state", int'(DBG_STATE), 2);

        // Direction toggle mid-fade
        do_reset();
        DIR_CNT = 0;
        run_periods(20);
        check_duties("tog_mid", 5, 5, 0);
        DIR_CNT = 1;
        run_periods(4);
        check_duties("tog_restore", 10, 0, 0);
        run_periods(4);
        check_duties("tog_toward_b", 9, 0, 1);

        // Transient count of 10
        do_reset();
        drive(1, 5);
        check("pre_transient_led_r", int'(LED_R), 1);
        drive(1, 10);
        check("transient_led_r", int'(LED_R), 0);
        check("transient_pe", int'(PERIOD_END), 0);
        drive(1, 0);
        check("post_transient_led_r", int'(LED_R), 1);
        drive(0, 9);
        check("ce_low_no_pe", int'(PERIOD_END), 0);
        check("ce_low_led_r", int'(LED_R), 1);
        drive(0, 0);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
